// File: rtl/rgb_framebuffer_ctrl_pkg.sv
// Shared types and geometry helpers for the packed-pixel framebuffer controller.
package fb_pkg;

  typedef enum logic [1:0] {CLEAR, IDLE, RD, MRG} fsm_state_e;

  localparam int unsigned FILL_MAX = 256;

  function automatic int unsigned ram_length(input int unsigned h, input int unsigned v,
                                             input int unsigned ppw);
    return (h * v + ppw - 1) / ppw;
  endfunction

  function automatic int unsigned addr_width(input int unsigned len);
    return (len > 1) ? $clog2(len) : 1;
  endfunction

  function automatic int unsigned pix_word(input int unsigned x, input int unsigned y,
                                           input int unsigned h, input int unsigned ppw);
    return (y * h + x) / ppw;
  endfunction

  function automatic int unsigned pix_lane(input int unsigned x, input int unsigned y,
                                           input int unsigned h, input int unsigned ppw);
    return (y * h + x) % ppw;
  endfunction

  // Replicates one colour into every lane of a word; callers slice the low bits they need.
  function automatic logic [FILL_MAX-1:0] pack_fill(input int unsigned color,
                                                    input int unsigned cw,
                                                    input int unsigned ppw);
    logic [FILL_MAX-1:0] w;
    w = '0;
    for (int unsigned i = 0; i < ppw; i++)
      for (int unsigned b = 0; b < cw; b++)
        if (i * cw + b < FILL_MAX) w[i * cw + b] = color[b];
    return w;
  endfunction

endpackage

// File: rtl/rgb_framebuffer_ctrl_if.sv
// Pixel-write handshake bundle between the pixel source and the framebuffer.
interface rgb_framebuffer_ctrl_if #(
  parameter int unsigned X_W = 7,
  parameter int unsigned Y_W = 6,
  parameter int unsigned C_W = 3
);
  logic           wr_valid;
  logic           wr_ready;
  logic [X_W-1:0] wr_x;
  logic [Y_W-1:0] wr_y;
  logic [C_W-1:0] wr_rgb;

  modport master (output wr_valid, output wr_x, output wr_y, output wr_rgb, input wr_ready);
  modport slave  (input wr_valid, input wr_x, input wr_y, input wr_rgb, output wr_ready);
endinterface

// File: rtl/rgb_framebuffer_ctrl_dpram.sv
// Simple dual-port RAM: one write port, one synchronous read-first read port.
module fb_dpram #(
  parameter int unsigned DATA_W = 6,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DEPTH  = 2400
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/rgb_framebuffer_ctrl.sv
// Packed-pixel framebuffer: 2-cycle display read path, RMW pixel writes during blanking, clear engine.
module rgb_framebuffer_ctrl
  import fb_pkg::*;
#(
  parameter int unsigned COLOR_WIDTH  = 3,
  parameter int unsigned PIX_PER_WORD = 2,
  parameter int unsigned FB_H         = 80,
  parameter int unsigned FB_V         = 60,
  parameter int unsigned SCALE_SHIFT  = 3,
  parameter int unsigned X_WIRE_WIDTH = 11,
  parameter int unsigned Y_WIRE_WIDTH = 10,
  parameter int unsigned CLEAR_COLOR  = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    display_on,
  input  logic [X_WIRE_WIDTH-1:0] hpos,
  input  logic [Y_WIRE_WIDTH-1:0] vpos,
  output logic [COLOR_WIDTH-1:0]  rgb,
  rgb_framebuffer_ctrl_if.slave   wr,
  input  logic                    clear_req,
  output logic                    clear_busy
);
  localparam int unsigned RAMLENGTH  = ram_length(FB_H, FB_V, PIX_PER_WORD);
  localparam int unsigned ADDR_WIDTH = addr_width(RAMLENGTH);
  localparam int unsigned WORD_W     = COLOR_WIDTH * PIX_PER_WORD;
  localparam int unsigned LANE_W     = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
  localparam logic [FILL_MAX-1:0]   FILL_ALL   = pack_fill(CLEAR_COLOR, COLOR_WIDTH, PIX_PER_WORD);
  localparam logic [WORD_W-1:0]     CLEAR_WORD = FILL_ALL[WORD_W-1:0];
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(RAMLENGTH - 1);

  fsm_state_e state, next_state;

  logic [ADDR_WIDTH-1:0]  clr_addr, lat_addr, disp_addr, rd_addr, waddr;
  logic [LANE_W-1:0]      lat_lane, disp_lane, lane_d1;
  logic [COLOR_WIDTH-1:0] lat_rgb;
  logic [WORD_W-1:0]      rd_data, wdata, merged;
  logic                   clear_pending, we, accept, wr_in_range;
  logic                   in_range, on_d1, inr_d1;
  logic [X_WIRE_WIDTH-1:0] scr_x;
  logic [Y_WIRE_WIDTH-1:0] scr_y;

  assign scr_x     = hpos >> SCALE_SHIFT;
  assign scr_y     = vpos >> SCALE_SHIFT;
  assign in_range  = (32'(scr_x) < FB_H) && (32'(scr_y) < FB_V);
  assign disp_addr = ADDR_WIDTH'(pix_word(32'(scr_x), 32'(scr_y), FB_H, PIX_PER_WORD));
  assign disp_lane = LANE_W'(pix_lane(32'(scr_x), 32'(scr_y), FB_H, PIX_PER_WORD));

  // The display owns the read port while active; in blanking it carries the pending RMW address.
  assign rd_addr     = display_on ? disp_addr : lat_addr;
  assign wr_in_range = (32'(wr.wr_x) < FB_H) && (32'(wr.wr_y) < FB_V);

  always_comb begin
    merged = rd_data;
    merged[lat_lane * COLOR_WIDTH +: COLOR_WIDTH] = lat_rgb;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= CLEAR;
    else       state <= next_state;
  end

  always_comb begin
    next_state  = state;
    wr.wr_ready = 1'b0;
    clear_busy  = 1'b0;
    accept      = 1'b0;
    we          = 1'b0;
    waddr       = clr_addr;
    wdata       = CLEAR_WORD;
    case (state)
      CLEAR: begin
        clear_busy = 1'b1;
        we         = 1'b1;
        if (clr_addr == LAST_ADDR) next_state = IDLE;
      end
      IDLE: begin
        wr.wr_ready = !display_on && !clear_pending && !clear_req;
        if (clear_req) begin
          next_state = CLEAR;
        end else if (wr.wr_valid && wr.wr_ready) begin
          accept = 1'b1;
          if (wr_in_range) next_state = RD;
        end
      end
      RD: if (!display_on) next_state = MRG;
      MRG: begin
        we         = 1'b1;
        waddr      = lat_addr;
        wdata      = merged;
        next_state = (clear_pending || clear_req) ? CLEAR : IDLE;
      end
      default: next_state = CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clr_addr      <= '0;
      clear_pending <= 1'b0;
      lat_addr      <= '0;
      lat_lane      <= '0;
      lat_rgb       <= '0;
    end else begin
      if (state == CLEAR) clr_addr <= (clr_addr == LAST_ADDR) ? '0 : clr_addr + 1'b1;
      if (state == CLEAR)
        clear_pending <= 1'b0;
      else if (clear_req && (state == RD || state == MRG))
        clear_pending <= 1'b1;
      if (accept) begin
        lat_addr <= ADDR_WIDTH'(pix_word(32'(wr.wr_x), 32'(wr.wr_y), FB_H, PIX_PER_WORD));
        lat_lane <= LANE_W'(pix_lane(32'(wr.wr_x), 32'(wr.wr_y), FB_H, PIX_PER_WORD));
        lat_rgb  <= wr.wr_rgb;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      on_d1   <= 1'b0;
      inr_d1  <= 1'b0;
      lane_d1 <= '0;
      rgb     <= '0;
    end else begin
      on_d1   <= display_on;
      inr_d1  <= in_range;
      lane_d1 <= disp_lane;
      rgb     <= (on_d1 && inr_d1) ? rd_data[lane_d1 * COLOR_WIDTH +: COLOR_WIDTH] : '0;
    end
  end

  fb_dpram #(
    .DATA_W(WORD_W),
    .ADDR_W(ADDR_WIDTH),
    .DEPTH (RAMLENGTH)
  ) u_ram (
    .clk  (clk),
    .we   (we),
    .waddr(waddr),
    .wdata(wdata),
    .raddr(rd_addr),
    .rdata(rd_data)
  );
endmodule

// File: doc/rgb_framebuffer_ctrl.md
Name: rgb_framebuffer_ctrl

Overview:
- Parametrised successor to the RGB framebuffer memory: packed multi-pixel words, configurable colour depth, framebuffer size and upscale factor.
- Built-in clear engine replaces the external reset-counter sweep.
- Pixel writes use a valid/ready handshake with internal read-modify-write, allowed only during blanking.
- Sits between the VGA timing generator (hpos, vpos, display_on) and the pixel source, and drives the registered rgb output to the DAC/pins.

Parameters:
- COLOR_WIDTH, 3: bits per pixel.
- PIX_PER_WORD, 2: pixels packed per RAM word; word width = COLOR_WIDTH*PIX_PER_WORD.
- FB_H, 80: framebuffer width in pixels.
- FB_V, 60: framebuffer height in pixels.
- SCALE_SHIFT, 3: screen-to-framebuffer downscale; fb coordinate = screen coordinate >> SCALE_SHIFT.
- X_WIRE_WIDTH, 11: hpos width.
- Y_WIRE_WIDTH, 10: vpos width.
- CLEAR_COLOR, 0: colour written by the clear engine.
- Derived, not overridable: RAMLENGTH = ceil(FB_H*FB_V/PIX_PER_WORD) = 2400; ADDR_WIDTH = $clog2(RAMLENGTH) = 12.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  asynchronous, active-high reset.
- display_on  in  1  active video region from the timing generator.
- hpos  in  X_WIRE_WIDTH  screen x.
- vpos  in  Y_WIRE_WIDTH  screen y.
- rgb  out  COLOR_WIDTH  registered pixel colour.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accepted when wr_valid && wr_ready.
- wr_x  in  $clog2(FB_H)  framebuffer x.
- wr_y  in  $clog2(FB_V)  framebuffer y.
- wr_rgb  in  COLOR_WIDTH  colour to write.
- clear_req  in  1  single-cycle pulse: fill the framebuffer with CLEAR_COLOR.
- clear_busy  out  1  clear engine running.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high.
- Outputs on reset: rgb=0, wr_ready=0, clear_busy=1. Every state register is cleared and the FSM enters CLEAR at address 0 (automatic clear after reset).
- Addressing: pixel index p = y*FB_H + x; word address = p / PIX_PER_WORD; lane = p % PIX_PER_WORD. Lane 0 occupies the LSBs.
- Display read path, 2-cycle latency:
  - Cycle 0: compute the address from hpos>>SCALE_SHIFT and vpos>>SCALE_SHIFT.
  - Cycle 1: RAM read.
  - Cycle 2: lane mux and register into rgb.
  - display_on and the in-range flag are delayed by 2 cycles. rgb=0 when the delayed display_on=0 or the delayed flag shows the coordinate was outside FB_H x FB_V.
- RAM: simple dual-port, one write port and one synchronous read port, read-first. The display owns the read port whenever display_on=1.
- FSM states:
  - CLEAR: write packed CLEAR_COLOR at clr_addr, clr_addr++. Leave after writing RAMLENGTH-1; one word per cycle regardless of display_on, RAMLENGTH cycles total. Go to IDLE; clear_busy falls on that transition.
  - IDLE: wr_ready = !display_on && !clear_pending. On handshake, latch x, y and rgb, then go to RD.
    - If the latched coordinate is out of range: drop the write (no RAM change) and stay in IDLE. Still one handshake.
  - RD: issue the read only if display_on=0, otherwise hold in RD. Then go to MRG.
  - MRG: replace the lane in the read word and write the word back. Go to IDLE, or to CLEAR if clear_pending.
- Write throughput: one write per 3 cycles. The next RMW read occurs after the previous write, so same-word back-to-back writes are coherent.
- clear_req handling:
  - In IDLE: go to CLEAR next cycle; clear_busy=1 from the next cycle.
  - In RD or MRG: set clear_pending, finish the RMW, then CLEAR.
  - During CLEAR: ignored.
- display_on rising mid-RMW: RD stalls. MRG completes, since the write port is unaffected.
- Display read hitting a word being written in the same cycle returns the old data.
- Reset asserted mid-clear or mid-RMW: an in-flight write is lost and the clear restarts from address 0.

Decomposition:
- Package fb_pkg:
  - fsm_state_e {CLEAR, IDLE, RD, MRG}.
  - Functions for the RAMLENGTH/ADDR_WIDTH derivation, pixel-to-word address and lane.
  - Packed-fill function for CLEAR_COLOR.
- Sub-module fb_dpram: parametrised simple dual-port RAM, read-first, synchronous read, no reset on contents.

Test Plan:
- Reset for 3 cycles then release:
  - clear_busy=1 for exactly 2400 cycles, wr_ready=0 throughout.
  - Afterwards, display_on=1 at any (hpos,vpos) below 640x480 -> rgb=0 two cycles later.
- Write (60,50,3'b011) with display_on=0 (accept only when wr_valid && wr_ready):
  - Then display_on=1, hpos=480, vpos=400 -> rgb=3'b011 after 2 cycles.
  - hpos=488 (x=61, same word) -> rgb=0, proving RMW preserves the other lane.
- Back-to-back writes (40,20,3'b101) then (41,20,3'b110), same word:
  - hpos=320, vpos=160 -> 3'b101.
  - hpos=328 -> 3'b110.
  - Exactly 3 cycles between handshakes.
- Stalls and blanking:
  - wr_valid=1 with display_on=1 -> wr_ready=0 until display_on=0, then accepted.
  - Out-of-range write (80,0,3'b111) -> accepted, no RAM change.
  - hpos=640 -> rgb=0.
  - display_on=0 -> rgb=0 two cycles later.
- clear_req with the FSM in MRG:
  - clear_busy rises the cycle after the write-back.
  - Post-clear readback of (60,50) -> CLEAR_COLOR.
  - A second clear_req during CLEAR does not extend the 2400-cycle sweep.
- 10 random writes with x in 0..79, y in 0..59, rgb in 0..7, then read back at x*8, y*8 -> every value matches.
